// File: rtl/memory_lsu.sv
// Memory-stage load/store unit.
// Takes one access per instruction from the regM pipeline register, checks its
// alignment, and runs a single bus transaction: request, wait for the response,
// then pulse done. Load data is extracted and extended into valM.
// Store data is lane-replicated and byte-enabled.
// The pipeline is stalled from the first cycle of an aligned access until the
// done cycle.

module memory_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] regM_i_valE,
    input  logic [31:0] regM_i_valB,
    input  logic [3:0]  regM_i_mem_rw,
    output logic        dmem_o_req_valid,
    input  logic        dmem_i_req_ready,
    output logic [31:0] dmem_o_addr,
    output logic        dmem_o_we,
    output logic [3:0]  dmem_o_wstrb,
    output logic [31:0] dmem_o_wdata,
    input  logic        dmem_i_resp_valid,
    input  logic [31:0] dmem_i_rdata,
    output logic [31:0] memory_o_valM,
    output logic        memory_o_stall,
    output logic        memory_o_misalign,
    output logic        memory_o_done
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Access codes 1..8 are real memory operations; everything else is none.
    function automatic logic op_is_access(input logic [3:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Alignment: halfwords need addr[0]=0, words need addr[1:0]=0.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic r;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = lane[0];
            OP_LW, OP_SW:         r = (lane != 2'b00);
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte enables for a store placed at the given byte lane.
    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] lane);
        logic [3:0] r;
        case (op)
            OP_SB:   r = 4'b0001 << lane;
            OP_SH:   r = 4'b0011 << lane;
            OP_SW:   r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Store data replicated across all lanes so the strobes pick the right copy.
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] src);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{src[7:0]}};
            OP_SH:   r = {2{src[15:0]}};
            OP_SW:   r = src;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        logic [31:0] r;
        b_sh = word >> {lane, 3'b000};
        h_sh = word >> {lane[1], 4'b0000};
        case (op)
            OP_LB:   r = {{24{b_sh[7]}}, b_sh[7:0]};
            OP_LBU:  r = {24'd0, b_sh[7:0]};
            OP_LH:   r = {{16{h_sh[15]}}, h_sh[15:0]};
            OP_LHU:  r = {16'd0, h_sh[15:0]};
            OP_LW:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] addr_r;
    logic        we_r;
    logic [3:0]  wstrb_r;
    logic [31:0] wdata_r;
    logic [3:0]  op_r;
    logic [1:0]  lane_r;
    logic [31:0] valm_r;

    logic        access_s;
    logic        misalign_s;
    logic        start_s;

    // Decode the incoming regM access and decide whether a bus transaction starts.
    always_comb begin
        access_s   = op_is_access(regM_i_mem_rw);
        misalign_s = access_s && op_misaligned(regM_i_mem_rw, regM_i_valE[1:0]);
        start_s    = (state_r == ST_IDLE) && access_s && !misalign_s;
    end

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_i_req_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_i_resp_valid) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register; reset returns to IDLE so a pending response is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Latch the request fields at the start of an access; held until the next access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= 32'd0;
            we_r    <= 1'b0;
            wstrb_r <= 4'b0000;
            wdata_r <= 32'd0;
            op_r    <= 4'd0;
            lane_r  <= 2'd0;
        end else if (start_s) begin
            addr_r  <= {regM_i_valE[31:2], 2'b00};
            we_r    <= op_is_store(regM_i_mem_rw);
            wstrb_r <= store_strb(regM_i_mem_rw, regM_i_valE[1:0]);
            wdata_r <= store_data(regM_i_mem_rw, regM_i_valB);
            op_r    <= regM_i_mem_rw;
            lane_r  <= regM_i_valE[1:0];
        end else begin
            addr_r  <= addr_r;
            we_r    <= we_r;
            wstrb_r <= wstrb_r;
            wdata_r <= wdata_r;
            op_r    <= op_r;
            lane_r  <= lane_r;
        end
    end

    // Capture the extended load result when the load response arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valm_r <= 32'd0;
        end else if ((state_r == ST_WAIT) && dmem_i_resp_valid && op_is_load(op_r)) begin
            valm_r <= load_extract(op_r, lane_r, dmem_i_rdata);
        end else begin
            valm_r <= valm_r;
        end
    end

    // Drive outputs from state and latched fields; stall covers the start cycle too.
    always_comb begin
        dmem_o_req_valid  = (state_r == ST_REQ);
        dmem_o_addr       = addr_r;
        dmem_o_we         = we_r;
        dmem_o_wstrb      = wstrb_r;
        dmem_o_wdata      = wdata_r;
        memory_o_valM     = valm_r;
        memory_o_done     = (state_r == ST_DONE);
        memory_o_stall    = start_s || (state_r == ST_REQ) || (state_r == ST_WAIT);
        memory_o_misalign = (state_r == ST_IDLE) && misalign_s;
    end

endmodule

// File: tb/tb_memory_lsu.sv
// Self-checking bench for memory_lsu: directed scenarios followed by random
// accesses, checked against an arithmetic reference of the access rules.

module tb_memory_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] val_e;
    logic [31:0] val_b;
    logic [3:0]  mem_rw;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic [31:0] val_m;
    logic        stall;
    logic        misalign;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_valm = 32'd0;

    memory_lsu dut (
        .clk               (clk),
        .rst               (rst),
        .regM_i_valE       (val_e),
        .regM_i_valB       (val_b),
        .regM_i_mem_rw     (mem_rw),
        .dmem_o_req_valid  (req_valid),
        .dmem_i_req_ready  (req_ready),
        .dmem_o_addr       (addr),
        .dmem_o_we         (we),
        .dmem_o_wstrb      (wstrb),
        .dmem_o_wdata      (wdata),
        .dmem_i_resp_valid (resp_valid),
        .dmem_i_rdata      (rdata),
        .memory_o_valM     (val_m),
        .memory_o_stall    (stall),
        .memory_o_misalign (misalign),
        .memory_o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---- reference rules ----
    function automatic bit is_acc(input int op);
        return (op >= 1) && (op <= 8);
    endfunction

    function automatic bit is_load(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic int acc_size(input int op);
        if (op == 2 || op == 5 || op == 7) return 2;
        if (op == 3 || op == 8) return 4;
        return 1;
    endfunction

    function automatic bit is_mis(input int op, input logic [31:0] a);
        return is_acc(op) && ((a % acc_size(op)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned lane;
        logic [31:0] v;
        lane = a % 4;
        if (op == 3) return rd;
        if (op == 1 || op == 4) begin
            v = (rd >> (8 * lane)) & 32'h0000_00FF;
            if (op == 1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else begin
            v = (rd >> (8 * lane)) & 32'h0000_FFFF;
            if (op == 2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(input int op, input logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (op == 6) return 4'(1 << lane);
        if (op == 7) return 4'(3 << lane);
        if (op == 8) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] b);
        if (op == 6) return (b & 32'h0000_00FF) * 32'h0101_0101;
        if (op == 7) return (b & 32'h0000_FFFF) * 32'h0001_0001;
        if (op == 8) return b;
        return 32'd0;
    endfunction

    task automatic check_bus(input logic [31:0] ea, input logic ewe, input logic [3:0] es,
                             input logic [31:0] ed);
        check_val("req_valid", 32'(req_valid), 32'd1);
        check_val("addr", addr, ea);
        check_val("we", 32'(we), 32'(ewe));
        check_val("wstrb", 32'(wstrb), 32'(es));
        check_val("wdata", wdata, ed);
        check_val("stall_req", 32'(stall), 32'd1);
    endtask

    // Run one access; entered and left at 1 time unit after a rising edge.
    task automatic run_access(input int op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] rd, input int rdly, input int sdly);
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        logic        ewe;
        mem_rw = 4'(op); val_e = a; val_b = b; req_ready = 1'b0; resp_valid = 1'b0;
        if (!is_acc(op) || is_mis(op, a)) begin
            @(negedge clk);
            check_val("misalign", 32'(misalign), 32'(is_mis(op, a)));
            check_val("stall_noacc", 32'(stall), 32'd0);
            check_val("req_noacc", 32'(req_valid), 32'd0);
            check_val("valM_hold", val_m, exp_valm);
            @(posedge clk); #1;
            @(negedge clk);
            check_val("req_noacc2", 32'(req_valid), 32'd0);
            check_val("done_noacc", 32'(done), 32'd0);
            @(posedge clk); #1;
            mem_rw = 4'd0;
            return;
        end
        ea  = a & 32'hFFFF_FFFC;
        ewe = (op >= 6);
        es  = ref_strb(op, a);
        ed  = ref_wdata(op, b);
        @(negedge clk);
        check_val("stall_start", 32'(stall), 32'd1);
        check_val("misalign_ok", 32'(misalign), 32'd0);
        check_val("req_start", 32'(req_valid), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < rdly; k++) begin
            resp_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_bus(ea, ewe, es, ed);
            @(posedge clk); #1;
            val_e = $urandom; val_b = $urandom;
        end
        req_ready = 1'b1;
        resp_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_bus(ea, ewe, es, ed);
        @(posedge clk); #1;
        req_ready = 1'b0; resp_valid = 1'b0; val_e = $urandom; val_b = $urandom;
        for (int k = 0; k < sdly; k++) begin
            req_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("req_wait", 32'(req_valid), 32'd0);
            check_val("stall_wait", 32'(stall), 32'd1);
            check_val("done_wait", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        resp_valid = 1'b1; rdata = rd;
        @(negedge clk);
        check_val("stall_resp", 32'(stall), 32'd1);
        check_val("done_resp", 32'(done), 32'd0);
        @(posedge clk); #1;
        resp_valid = 1'($urandom_range(0, 1)); rdata = $urandom; mem_rw = 4'd0;
        if (is_load(op)) exp_valm = ref_load(op, a, rd);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("stall_done", 32'(stall), 32'd0);
        check_val("valM", val_m, exp_valm);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        check_val("done_after", 32'(done), 32'd0);
        check_val("valM_after", val_m, exp_valm);
        @(posedge clk); #1;
    endtask

    // Reset in WAIT (or REQ) followed by a stale response.
    task automatic run_reset(input bit in_wait);
        mem_rw = 4'd3; val_e = 32'h0000_0300; val_b = 32'd0;
        req_ready = 1'b0; resp_valid = 1'b0;
        @(posedge clk); #1;
        if (in_wait) begin
            req_ready = 1'b1;
            @(posedge clk); #1;
            req_ready = 1'b0;
        end
        @(negedge clk);
        check_val("req_before_rst", 32'(req_valid), in_wait ? 32'd0 : 32'd1);
        rst = 1'b0;
        #1;
        exp_valm = 32'd0;
        check_val("rst_req", 32'(req_valid), 32'd0);
        check_val("rst_valM", val_m, 32'd0);
        check_val("rst_addr", addr, 32'd0);
        check_val("rst_wstrb", 32'(wstrb), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        mem_rw = 4'd0;
        #1;
        check_val("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        resp_valid = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        check_val("stale_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        @(negedge clk);
        check_val("stale_done2", 32'(done), 32'd0);
        check_val("stale_req", 32'(req_valid), 32'd0);
        check_val("stale_valM", val_m, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int op;
        logic [31:0] a;
        rst = 1'b0; val_e = 32'd0; val_b = 32'd0; mem_rw = 4'd0;
        req_ready = 1'b0; resp_valid = 1'b0; rdata = 32'd0;
        @(negedge clk);
        check_val("reset_req", 32'(req_valid), 32'd0);
        check_val("reset_we", 32'(we), 32'd0);
        check_val("reset_wstrb", 32'(wstrb), 32'd0);
        check_val("reset_addr", addr, 32'd0);
        check_val("reset_wdata", wdata, 32'd0);
        check_val("reset_valM", val_m, 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_access(3, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
        run_access(1, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 0);
        run_access(4, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 0);
        run_access(7, 32'h0000_0206, 32'h0000_ABCD, 32'd0, 0, 0);
        run_access(3, 32'h0000_0102, 32'd0, 32'd0, 0, 0);
        run_access(8, 32'h0000_0400, 32'h1357_9BDF, 32'd0, 4, 1);
        run_access(12, 32'h0000_0500, 32'd0, 32'd0, 0, 0);
        run_access(2, 32'h0000_0102, 32'd0, 32'h8001_7FFF, 1, 2);
        run_reset(1'b1);
        run_access(5, 32'h0000_0100, 32'd0, 32'h8001_7FFF, 0, 0);
        run_reset(1'b0);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 15);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((acc_size(op) > 1) ? 32'(acc_size(op) - 1) : 32'd0);
            run_access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
